sram_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing the single-port async SRAM slave.

---
 rtl/sram_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of the single-port SRAM block.
// Registered grant held for a whole cyc burst, optionally capped by MAX_HOLD beats under contention.
module sram_arbiter #(
  parameter int ADR_W    = 19,
  parameter int DAT_W    = 16,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  // Encoding doubles as the one-hot grant {m1,m0}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state_q, state_d, other_gnt;
  logic             last_q, last_d;
  logic [CNT_W-1:0] hold_q;
  logic             own_cyc, oth_cyc, beat;

  assign gnt_o    = state_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    other_gnt = IDLE;
    own_cyc   = 1'b0;
    oth_cyc   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;

    unique case (state_q)
      G0: begin
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        m0_ack_o  = s_ack_i;
        own_cyc   = m0_cyc_i;
        oth_cyc   = m1_cyc_i;
        other_gnt = G1;
      end
      G1: begin
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        m1_ack_o  = s_ack_i;
        own_cyc   = m1_cyc_i;
        oth_cyc   = m0_cyc_i;
        other_gnt = G0;
      end
      default: ;
    endcase

    beat = s_stb_o & s_ack_i;

    unique case (state_q)
      IDLE: begin
        // last_q holds the index of the master granted last; a tie goes to the other one.
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? G0 : G1;
        else if (m0_cyc_i)        state_d = G0;
        else if (m1_cyc_i)        state_d = G1;
      end
      G0, G1: begin
        if (!own_cyc) begin
          state_d = oth_cyc ? other_gnt : IDLE;
          last_d  = (state_q == G1);
        end else if (MAX_HOLD != 0 && oth_cyc && beat && hold_q == HOLD_LAST) begin
          state_d = other_gnt;
          last_d  = (state_q == G1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (state_d != state_q)
        hold_q <= '0;
      else if (beat && oth_cyc && hold_q != HOLD_MAX)
        hold_q <= hold_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=0) run side by side
// against a cycle-level reference model of the grant rules and a small SRAM responder.
module tb_sram_arbiter;

  localparam int ADR_W = 19;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             cyc   [2][2];
  logic             stb   [2][2];
  logic             we    [2][2];
  logic [SEL_W-1:0] sel   [2][2];
  logic [ADR_W-1:0] adr   [2][2];
  logic [DAT_W-1:0] wdat  [2][2];
  logic             ack_en[2];

  logic [1:0]       gnt   [2];
  logic             s_stb [2];
  logic             s_we  [2];
  logic             s_ack [2];
  logic [SEL_W-1:0] s_sel [2];
  logic [ADR_W-1:0] s_adr [2];
  logic [DAT_W-1:0] s_wd  [2];
  logic [DAT_W-1:0] s_rd  [2];
  logic [DAT_W-1:0] rd0   [2];
  logic [DAT_W-1:0] rd1   [2];
  logic             ack0  [2];
  logic             ack1  [2];

  logic [DAT_W-1:0] mem [2][256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign s_ack[g] = s_stb[g] & ack_en[g];
    assign s_rd[g]  = mem[g][s_adr[g][7:0]];

    sram_arbiter #(
      .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .MAX_HOLD(g == 0 ? 8 : 0)
    ) u_dut (
      .clk_i   (clk),          .reset_i (rst),
      .m0_cyc_i(cyc[g][0]),    .m0_stb_i(stb[g][0]),   .m0_we_i (we[g][0]),
      .m0_sel_i(sel[g][0]),    .m0_adr_i(adr[g][0]),   .m0_dat_i(wdat[g][0]),
      .m0_dat_o(rd0[g]),       .m0_ack_o(ack0[g]),
      .m1_cyc_i(cyc[g][1]),    .m1_stb_i(stb[g][1]),   .m1_we_i (we[g][1]),
      .m1_sel_i(sel[g][1]),    .m1_adr_i(adr[g][1]),   .m1_dat_i(wdat[g][1]),
      .m1_dat_o(rd1[g]),       .m1_ack_o(ack1[g]),
      .s_stb_o (s_stb[g]),     .s_we_o  (s_we[g]),     .s_sel_o (s_sel[g]),
      .s_adr_o (s_adr[g]),     .s_dat_o (s_wd[g]),     .s_dat_i (s_rd[g]),
      .s_ack_i (s_ack[g]),     .gnt_o   (gnt[g])
    );
  end

  // Reference model: owner (-1 idle, 0, 1), master granted last, beats taken under contention.
  int own [2];
  int last[2];
  int held[2];
  int n_checks;
  int n_pass;

  function automatic int max_hold(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      ack_en[d] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        cyc[d][m] = 1'b0; stb[d][m] = 1'b0; we[d][m] = 1'b0;
        sel[d][m] = '0;   adr[d][m] = '0;   wdat[d][m] = '0;
      end
    end
  endtask

  // Compare every DUT output against the model for the inputs of the current cycle.
  task automatic settle_check();
    #1;
    for (int d = 0; d < 2; d++) begin
      int o;
      logic [1:0]       e_gnt;
      logic             e_stb, e_we, e_ack0, e_ack1;
      logic [SEL_W-1:0] e_sel;
      logic [ADR_W-1:0] e_adr;
      logic [DAT_W-1:0] e_wd, e_rd;
      o = own[d];
      e_gnt = 2'b00; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_wd = '0;
      if (o >= 0) begin
        e_gnt = (o == 0) ? 2'b01 : 2'b10;
        e_stb = stb[d][o]; e_we = we[d][o]; e_sel = sel[d][o];
        e_adr = adr[d][o]; e_wd = wdat[d][o];
      end
      e_ack0 = (o == 0) && e_stb && ack_en[d];
      e_ack1 = (o == 1) && e_stb && ack_en[d];
      e_rd   = mem[d][e_adr[7:0]];

      n_checks++; if (gnt[d] !== e_gnt) $display("FAIL gnt dut%0d t=%0t got %b want %b", d, $time, gnt[d], e_gnt); else n_pass++;
      n_checks++; if (s_stb[d] !== e_stb) $display("FAIL s_stb dut%0d t=%0t got %b want %b", d, $time, s_stb[d], e_stb); else n_pass++;
      n_checks++; if (s_we[d] !== e_we) $display("FAIL s_we dut%0d t=%0t got %b want %b", d, $time, s_we[d], e_we); else n_pass++;
      n_checks++; if (s_sel[d] !== e_sel) $display("FAIL s_sel dut%0d t=%0t got %b want %b", d, $time, s_sel[d], e_sel); else n_pass++;
      n_checks++; if (s_adr[d] !== e_adr) $display("FAIL s_adr dut%0d t=%0t got %h want %h", d, $time, s_adr[d], e_adr); else n_pass++;
      n_checks++; if (s_wd[d] !== e_wd) $display("FAIL s_dat dut%0d t=%0t got %h want %h", d, $time, s_wd[d], e_wd); else n_pass++;
      n_checks++; if (ack0[d] !== e_ack0) $display("FAIL m0_ack dut%0d t=%0t got %b want %b", d, $time, ack0[d], e_ack0); else n_pass++;
      n_checks++; if (ack1[d] !== e_ack1) $display("FAIL m1_ack dut%0d t=%0t got %b want %b", d, $time, ack1[d], e_ack1); else n_pass++;
      n_checks++; if (rd0[d] !== e_rd) $display("FAIL m0_dat dut%0d t=%0t got %h want %h", d, $time, rd0[d], e_rd); else n_pass++;
      n_checks++; if (rd1[d] !== e_rd) $display("FAIL m1_dat dut%0d t=%0t got %h want %h", d, $time, rd1[d], e_rd); else n_pass++;
    end
  endtask

  // Clock edge: SRAM responder commits writes, model applies the grant rules.
  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int o, p;
      bit beat;
      o = own[d];
      if (o >= 0 && stb[d][o] && ack_en[d] && we[d][o]) begin
        if (sel[d][o][0]) mem[d][adr[d][o][7:0]][7:0]  = wdat[d][o][7:0];
        if (sel[d][o][1]) mem[d][adr[d][o][7:0]][15:8] = wdat[d][o][15:8];
      end
      if (rst) begin
        own[d] = -1; last[d] = 1; held[d] = 0;
      end else if (o < 0) begin
        if (cyc[d][0] && cyc[d][1]) own[d] = 1 - last[d];
        else if (cyc[d][0])         own[d] = 0;
        else if (cyc[d][1])         own[d] = 1;
      end else begin
        p = 1 - o;
        beat = stb[d][o] && ack_en[d];
        if (!cyc[d][o]) begin
          own[d] = cyc[d][p] ? p : -1; last[d] = o; held[d] = 0;
        end else if (max_hold(d) != 0 && cyc[d][p] && beat && held[d] == max_hold(d) - 1) begin
          own[d] = p; last[d] = o; held[d] = 0;
        end else if (beat && cyc[d][p] && held[d] < max_hold(d)) begin
          held[d]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle_check();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; last[d] = 1; held[d] = 0;
    end
    @(negedge clk);
    tick();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b00) $display("FAIL reset_gnt dut%0d got %b want 00", d, gnt[d]); else n_pass++;
      n_checks++; if (s_stb[d] !== 1'b0) $display("FAIL reset_stb dut%0d got %b want 0", d, s_stb[d]); else n_pass++;
      n_checks++; if ({ack0[d], ack1[d]} !== 2'b00) $display("FAIL reset_acks dut%0d got %b want 00", d, {ack0[d], ack1[d]}); else n_pass++;
    end
    rst = 1'b0;
    advance();
  endtask

  task automatic test_single_write();
    for (int d = 0; d < 2; d++) begin
      cyc[d][0] = 1'b1; stb[d][0] = 1'b1; we[d][0] = 1'b1;
      sel[d][0] = 2'b11; adr[d][0] = 19'h00010; wdat[d][0] = 16'hBEEF;
    end
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ack0[d] !== 1'b0) $display("FAIL wr_idle_ack dut%0d got %b want 0", d, ack0[d]); else n_pass++;
    end
    advance();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b01) $display("FAIL wr_gnt dut%0d got %b want 01", d, gnt[d]); else n_pass++;
      n_checks++; if (s_adr[d] !== 19'h00010) $display("FAIL wr_adr dut%0d got %h want 00010", d, s_adr[d]); else n_pass++;
      n_checks++; if (s_wd[d] !== 16'hBEEF) $display("FAIL wr_dat dut%0d got %h want beef", d, s_wd[d]); else n_pass++;
      n_checks++; if (s_we[d] !== 1'b1) $display("FAIL wr_we dut%0d got %b want 1", d, s_we[d]); else n_pass++;
      n_checks++; if ({ack1[d], ack0[d]} !== 2'b01) $display("FAIL wr_acks dut%0d got %b want 01", d, {ack1[d], ack0[d]}); else n_pass++;
    end
    advance();
    idle_inputs();
    tick();
    // m1 reads the word back through the same slave.
    for (int d = 0; d < 2; d++) begin
      cyc[d][1] = 1'b1; stb[d][1] = 1'b1; adr[d][1] = 19'h00010;
    end
    tick();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ack1[d] !== 1'b1) $display("FAIL rd_ack dut%0d got %b want 1", d, ack1[d]); else n_pass++;
      n_checks++; if (rd1[d] !== 16'hBEEF) $display("FAIL rd_dat dut%0d got %h want beef", d, rd1[d]); else n_pass++;
    end
    advance();
    idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        cyc[d][m] = 1'b1; stb[d][m] = 1'b1; adr[d][m] = 19'($urandom);
      end
    tick();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b01) $display("FAIL tie_first dut%0d got %b want 01", d, gnt[d]); else n_pass++;
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      cyc[d][0] = 1'b0; stb[d][0] = 1'b0;
    end
    tick();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b10) $display("FAIL tie_handover dut%0d got %b want 10", d, gnt[d]); else n_pass++;
    end
    advance();
    idle_inputs();
    tick();
    // m0 alone then releases to idle, so m1 is owed the next tie.
    for (int d = 0; d < 2; d++) begin
      cyc[d][0] = 1'b1; stb[d][0] = 1'b1;
    end
    tick();
    tick();
    idle_inputs();
    tick();
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        cyc[d][m] = 1'b1; stb[d][m] = 1'b1;
      end
    tick();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b10) $display("FAIL tie_alternate dut%0d got %b want 10", d, gnt[d]); else n_pass++;
    end
    advance();
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_stream();
    int  a0[2], a1[2], contended[2], m0_at_m1[2];
    bit  done;
    done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      a0[d] = 0; a1[d] = 0; contended[d] = 0; m0_at_m1[d] = -1;
    end
    do_reset();
    for (int k = 0; k < 200 && !done; k++) begin
      for (int d = 0; d < 2; d++) begin
        cyc[d][0] = (a0[d] < 20);            stb[d][0] = cyc[d][0];
        adr[d][0] = 19'(k);                  we[d][0]  = 1'b0;
        cyc[d][1] = (a0[d] >= 2) && (a1[d] < 1); stb[d][1] = cyc[d][1];
        adr[d][1] = 19'h00080;               we[d][1]  = 1'b0;
      end
      settle_check();
      for (int d = 0; d < 2; d++) begin
        if (ack0[d] === 1'b1) begin
          a0[d]++;
          if (cyc[d][1] && a1[d] == 0) contended[d]++;
        end
        if (ack1[d] === 1'b1) begin
          if (a1[d] == 0) m0_at_m1[d] = a0[d];
          a1[d]++;
        end
      end
      advance();
      done = (a0[0] == 20) && (a1[0] == 1) && (a0[1] == 20) && (a1[1] == 1);
    end
    n_checks++; if (!done) $display("FAIL hold_timeout got not-done want done"); else n_pass++;
    n_checks++; if (contended[0] != 8) $display("FAIL hold_limit8 got %0d want 8", contended[0]); else n_pass++;
    n_checks++; if (m0_at_m1[0] != 10) $display("FAIL hold_switch8 got %0d want 10", m0_at_m1[0]); else n_pass++;
    n_checks++; if (contended[1] != 18) $display("FAIL hold_nolimit got %0d want 18", contended[1]); else n_pass++;
    n_checks++; if (m0_at_m1[1] != 20) $display("FAIL hold_switch0 got %0d want 20", m0_at_m1[1]); else n_pass++;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (a0[d] != 20) $display("FAIL hold_m0_total dut%0d got %0d want 20", d, a0[d]); else n_pass++;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      cyc[d][1] = 1'b1; stb[d][1] = 1'b1; we[d][1] = 1'b1;
      sel[d][1] = 2'b01; adr[d][1] = 19'h00033; wdat[d][1] = 16'($urandom);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b00) $display("FAIL rst_mid_gnt dut%0d got %b want 00", d, gnt[d]); else n_pass++;
      n_checks++; if (s_stb[d] !== 1'b0) $display("FAIL rst_mid_stb dut%0d got %b want 0", d, s_stb[d]); else n_pass++;
      n_checks++; if (ack1[d] !== 1'b0) $display("FAIL rst_mid_ack dut%0d got %b want 0", d, ack1[d]); else n_pass++;
    end
    advance();
    settle_check();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 2'b10) $display("FAIL rst_regrant dut%0d got %b want 10", d, gnt[d]); else n_pass++;
    end
    advance();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int d = 0; d < 2; d++) begin
        for (int m = 0; m < 2; m++) begin
          if ($urandom_range(0, 7) == 0) cyc[d][m] = ~cyc[d][m];
          stb[d][m]  = cyc[d][m] && ($urandom_range(0, 3) != 0);
          we[d][m]   = 1'($urandom);
          sel[d][m]  = 2'($urandom);
          adr[d][m]  = 19'($urandom);
          wdat[d][m] = 16'($urandom);
        end
        ack_en[d] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; last[d] = 1; held[d] = 0;
      for (int i = 0; i < 256; i++) mem[d][i] = 16'($urandom);
    end
    test_reset();
    test_single_write();
    test_tie();
    test_hold_stream();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
